pipe_stage_reg: RTL and testbench

//  Parametrised pipeline-stage register for the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_data_reg.sv | 26 ++
 rtl/pipe_stage_reg.sv | 162 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline-stage registers.
//  ST_EMPTY / ST_ONE / ST_FULL : occupancy states of a stage register
//  DEF_WIDTH / DEF_CNT_W       : default payload and stall-counter widths
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;  // only reachable with a skid entry

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/pipe_data_reg.sv
// Load-enabled payload register with asynchronous reset to RESET_VAL.
//  clk   in  1      rising-edge clock
//  reset in  1      asynchronous, active-high; q <= RESET_VAL
//  load  in  1      capture d on the next rising edge
//  d     in  WIDTH  next value
//  q     out WIDTH  stored value
module pipe_data_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready
// handshake, synchronous flush, optional 2-entry skid buffer and a
// saturating stall-cycle counter.
//  clk         in  1      rising-edge clock
//  reset       in  1      asynchronous, active-high
//  flush       in  1      synchronous flush, discards held entries
//  clr_stats   in  1      synchronous clear of stall_count
//  in_valid    in  1      upstream payload valid
//  in_ready    out 1      stage can accept this cycle
//  in_data     in  WIDTH  upstream payload
//  out_valid   out 1      payload valid toward downstream
//  out_ready   in  1      downstream accepts
//  out_data    out WIDTH  payload, always from the main register
//  stall_count out CNT_W  cycles with out_valid & ~out_ready, saturating
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SKID      = 1,
  parameter int               CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             clr_stats,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_count
);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]       state;
  logic [1:0]       nextState;
  logic             outValidInt;
  logic             inReadyInt;
  logic             inFire;
  logic             outFire;
  logic             mainLoad;
  logic             skidLoad;
  logic [WIDTH-1:0] mainD;
  logic [WIDTH-1:0] mainQ;
  logic [WIDTH-1:0] skidQ;
  logic [CNT_W-1:0] stallCnt;

  assign outValidInt = (state != ST_EMPTY);

  // With a skid entry, in_ready depends only on registered state (plus the
  // flush/reset gates), never on out_ready.
  generate
    if (SKID != 0) begin : gReadySkid
      assign inReadyInt = (state != ST_FULL) & ~flush & ~reset;
    end else begin : gReadyPass
      assign inReadyInt = (~outValidInt | out_ready) & ~flush & ~reset;
    end
  endgenerate

  assign inFire  = in_valid & inReadyInt;
  assign outFire = outValidInt & out_ready;

  always_comb begin
    nextState = state;
    mainLoad  = 1'b0;
    skidLoad  = 1'b0;
    mainD     = in_data;
    if (flush) begin
      // in_ready is low, so nothing is loaded; data registers keep contents.
      nextState = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (inFire) begin
            nextState = ST_ONE;
            mainLoad  = 1'b1;
          end
        end
        ST_ONE: begin
          if (inFire && outFire) begin
            mainLoad = 1'b1;
          end else if (inFire) begin
            // Without a skid entry this branch cannot occur: in_ready while
            // valid implies out_ready, so inFire implies outFire.
            nextState = ST_FULL;
            skidLoad  = 1'b1;
          end else if (outFire) begin
            nextState = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (outFire) begin
            nextState = ST_ONE;
            mainLoad  = 1'b1;
            mainD     = skidQ;
          end
        end
        default: nextState = ST_EMPTY;
      endcase
    end
  end

  // Stage boundary: occupancy state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= nextState;
    end
  end

  // Stage boundary: payload registers
  pipe_data_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) uMain (
    .clk   (clk),
    .reset (reset),
    .load  (mainLoad),
    .d     (mainD),
    .q     (mainQ)
  );

  generate
    if (SKID != 0) begin : gSkid
      pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) uSkid (
        .clk   (clk),
        .reset (reset),
        .load  (skidLoad),
        .d     (in_data),
        .q     (skidQ)
      );
    end else begin : gNoSkid
      assign skidQ = RESET_VAL;
    end
  endgenerate

  // Stage boundary: stall statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (clr_stats) begin
      stallCnt <= '0;
    end else if (outValidInt && !out_ready) begin
      stallCnt <= satInc(stallCnt);
    end
  end

  assign in_ready    = inReadyInt;
  assign out_valid   = outValidInt;
  assign out_data    = mainQ;
  assign stall_count = stallCnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: dutA is the skid variant (RESET_VAL
// DEADBEEF, 4-bit stall counter), dutB the single-entry variant.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;

  logic        aFlush, aClr, aInValid, aInReady, aOutValid, aOutReady;
  logic [31:0] aInData, aOutData;
  logic [3:0]  aStall;

  logic        bFlush, bClr, bInValid, bInReady, bOutValid, bOutReady;
  logic [31:0] bInData, bOutData;
  logic [15:0] bStall;

  int nCmp = 0;
  int nErr = 0;
  logic [31:0] modelQ[$];

  pipe_stage_reg #(
    .WIDTH(32), .RESET_VAL(32'hDEADBEEF), .SKID(1), .CNT_W(4)
  ) dutA (
    .clk(clk), .reset(reset), .flush(aFlush), .clr_stats(aClr),
    .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
    .stall_count(aStall)
  );

  pipe_stage_reg #(
    .WIDTH(32), .RESET_VAL(32'h0), .SKID(0), .CNT_W(16)
  ) dutB (
    .clk(clk), .reset(reset), .flush(bFlush), .clr_stats(bClr),
    .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
    .stall_count(bStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    nCmp++; if (aOutValid !== 1'b0) begin nErr++; $display("FAIL rst_out_valid: got %b expected 0", aOutValid); end
    nCmp++; if (aOutData !== 32'hDEADBEEF) begin nErr++; $display("FAIL rst_out_data: got %h expected deadbeef", aOutData); end
    nCmp++; if (aInReady !== 1'b0) begin nErr++; $display("FAIL rst_in_ready: got %b expected 0", aInReady); end
    step();
    reset = 1'b0;
    #1;
    nCmp++; if (aInReady !== 1'b1) begin nErr++; $display("FAIL rel_in_ready: got %b expected 1", aInReady); end
    nCmp++; if (bInReady !== 1'b1) begin nErr++; $display("FAIL rel_in_ready_b: got %b expected 1", bInReady); end
    // load one word, stall it, then pulse reset mid-stream
    aInValid = 1'b1; aInData = 32'h55; aOutReady = 1'b0;
    step();
    aInValid = 1'b0;
    #1;
    nCmp++; if (aOutData !== 32'h55) begin nErr++; $display("FAIL load_data: got %h expected 00000055", aOutData); end
    step();
    nCmp++; if (aStall !== 4'd1) begin nErr++; $display("FAIL stall_one: got %0d expected 1", aStall); end
    reset = 1'b1;
    #1;
    nCmp++; if (aOutValid !== 1'b0) begin nErr++; $display("FAIL mid_rst_valid: got %b expected 0", aOutValid); end
    nCmp++; if (aOutData !== 32'hDEADBEEF) begin nErr++; $display("FAIL mid_rst_data: got %h expected deadbeef", aOutData); end
    nCmp++; if (aInReady !== 1'b0) begin nErr++; $display("FAIL mid_rst_ready: got %b expected 0", aInReady); end
    nCmp++; if (aStall !== 4'd0) begin nErr++; $display("FAIL mid_rst_stall: got %0d expected 0", aStall); end
    step();
    reset = 1'b0;
    #1;
    nCmp++; if (aInReady !== 1'b1) begin nErr++; $display("FAIL rel2_in_ready: got %b expected 1", aInReady); end
    nCmp++; if (aOutValid !== 1'b0) begin nErr++; $display("FAIL rel2_valid: got %b expected 0", aOutValid); end
  endtask

  task automatic test_stream();
    aOutReady = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      aInValid = 1'b1; aInData = 32'(i);
      #1;
      nCmp++; if (aInReady !== 1'b1) begin nErr++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, aInReady); end
      step();
      nCmp++; if (aOutValid !== 1'b1 || aOutData !== 32'(i)) begin
        nErr++; $display("FAIL stream_out[%0d]: got v=%b d=%h expected v=1 d=%h", i, aOutValid, aOutData, 32'(i));
      end
    end
    aInValid = 1'b0;
    step();
    nCmp++; if (aOutValid !== 1'b0) begin nErr++; $display("FAIL stream_drain: got %b expected 0", aOutValid); end
  endtask

  task automatic test_skid();
    aOutReady = 1'b0;
    aInValid = 1'b1; aInData = 32'hA;
    step();
    aInData = 32'hB;
    #1;
    nCmp++; if (aInReady !== 1'b1) begin nErr++; $display("FAIL skid_ready_one: got %b expected 1", aInReady); end
    step();
    aInData = 32'hD;
    #1;
    nCmp++; if (aInReady !== 1'b0) begin nErr++; $display("FAIL skid_ready_full: got %b expected 0", aInReady); end
    nCmp++; if (aOutData !== 32'hA) begin nErr++; $display("FAIL skid_main: got %h expected 0000000a", aOutData); end
    step();
    nCmp++; if (aOutData !== 32'hA || aOutValid !== 1'b1) begin nErr++; $display("FAIL skid_hold: got v=%b d=%h expected v=1 d=0000000a", aOutValid, aOutData); end
    aInValid = 1'b0; aOutReady = 1'b1;
    #1;
    nCmp++; if (aInReady !== 1'b0) begin nErr++; $display("FAIL skid_no_comb_path: got %b expected 0", aInReady); end
    step();
    nCmp++; if (aOutData !== 32'hB || aOutValid !== 1'b1) begin nErr++; $display("FAIL skid_second: got v=%b d=%h expected v=1 d=0000000b", aOutValid, aOutData); end
    step();
    nCmp++; if (aOutValid !== 1'b0) begin nErr++; $display("FAIL skid_empty: got %b expected 0", aOutValid); end
    nCmp++; if (aStall !== 4'd2) begin nErr++; $display("FAIL skid_stall_cnt: got %0d expected 2", aStall); end
  endtask

  task automatic test_flush();
    aOutReady = 1'b0;
    aInValid = 1'b1; aInData = 32'h11;
    step();
    aInData = 32'h22;
    step();
    aFlush = 1'b1; aInData = 32'hC;
    #1;
    nCmp++; if (aInReady !== 1'b0) begin nErr++; $display("FAIL flush_ready: got %b expected 0", aInReady); end
    step();
    aFlush = 1'b0; aInValid = 1'b0;
    #1;
    nCmp++; if (aOutValid !== 1'b0) begin nErr++; $display("FAIL flush_valid: got %b expected 0", aOutValid); end
    nCmp++; if (aOutData !== 32'h11) begin nErr++; $display("FAIL flush_data_kept: got %h expected 00000011", aOutData); end
    aInValid = 1'b1; aInData = 32'h33; aOutReady = 1'b1;
    #1;
    nCmp++; if (aInReady !== 1'b1) begin nErr++; $display("FAIL post_flush_ready: got %b expected 1", aInReady); end
    step();
    aInValid = 1'b0;
    nCmp++; if (aOutValid !== 1'b1 || aOutData !== 32'h33) begin nErr++; $display("FAIL post_flush_data: got v=%b d=%h expected v=1 d=00000033", aOutValid, aOutData); end
    step();
    nCmp++; if (aOutValid !== 1'b0) begin nErr++; $display("FAIL post_flush_drain: got %b expected 0", aOutValid); end
  endtask

  task automatic test_stall_count();
    logic [3:0] e;
    aClr = 1'b1;
    step();
    aClr = 1'b0;
    nCmp++; if (aStall !== 4'd0) begin nErr++; $display("FAIL clr_initial: got %0d expected 0", aStall); end
    aOutReady = 1'b0; aInValid = 1'b1; aInData = 32'h44;
    step();
    aInValid = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      step();
      e = (j > 15) ? 4'd15 : 4'(j);
      nCmp++; if (aStall !== e) begin nErr++; $display("FAIL stall_sat[%0d]: got %0d expected %0d", j, aStall, e); end
    end
    nCmp++; if (aOutData !== 32'h44 || aOutValid !== 1'b1) begin nErr++; $display("FAIL stall_hold: got v=%b d=%h expected v=1 d=00000044", aOutValid, aOutData); end
    aClr = 1'b1;
    step();
    aClr = 1'b0;
    nCmp++; if (aStall !== 4'd0) begin nErr++; $display("FAIL clr_wins: got %0d expected 0", aStall); end
    step(); step(); step();
    nCmp++; if (aStall !== 4'd3) begin nErr++; $display("FAIL stall_three: got %0d expected 3", aStall); end
    aOutReady = 1'b1; aFlush = 1'b1;
    step();
    aFlush = 1'b0;
    nCmp++; if (aStall !== 4'd3) begin nErr++; $display("FAIL flush_keeps_cnt: got %0d expected 3", aStall); end
    nCmp++; if (aOutValid !== 1'b0) begin nErr++; $display("FAIL flush_empty: got %b expected 0", aOutValid); end
  endtask

  task automatic test_soak_skid();
    modelQ.delete();
    for (int c = 0; c < 300; c++) begin
      aInValid = 1'($urandom_range(0, 1));
      aInData = $urandom;
      aOutReady = 1'($urandom_range(0, 1));
      #1;
      nCmp++; if (aOutValid !== (modelQ.size() != 0)) begin nErr++; $display("FAIL soakA_valid[%0d]: got %b expected %b", c, aOutValid, modelQ.size() != 0); end
      nCmp++; if (aInReady !== (modelQ.size() < 2)) begin nErr++; $display("FAIL soakA_ready[%0d]: got %b expected %b", c, aInReady, modelQ.size() < 2); end
      if (modelQ.size() != 0) begin
        nCmp++; if (aOutData !== modelQ[0]) begin nErr++; $display("FAIL soakA_data[%0d]: got %h expected %h", c, aOutData, modelQ[0]); end
      end
      if (aOutValid && aOutReady && modelQ.size() != 0) void'(modelQ.pop_front());
      if (aInValid && aInReady) modelQ.push_back(aInData);
      step();
    end
    aInValid = 1'b0; aOutReady = 1'b1;
    step(); step();
  endtask

  task automatic test_skid0();
    bOutReady = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bInValid = 1'b1; bInData = 32'(i);
      #1;
      nCmp++; if (bInReady !== 1'b1) begin nErr++; $display("FAIL b_stream_ready[%0d]: got %b expected 1", i, bInReady); end
      step();
      nCmp++; if (bOutValid !== 1'b1 || bOutData !== 32'(i)) begin
        nErr++; $display("FAIL b_stream_out[%0d]: got v=%b d=%h expected v=1 d=%h", i, bOutValid, bOutData, 32'(i));
      end
    end
    bInValid = 1'b0;
    step();
    nCmp++; if (bOutValid !== 1'b0) begin nErr++; $display("FAIL b_stream_drain: got %b expected 0", bOutValid); end
    bInValid = 1'b1; bInData = 32'h77;
    step();
    bInValid = 1'b0; bOutReady = 1'b0;
    #1;
    nCmp++; if (bInReady !== 1'b0) begin nErr++; $display("FAIL b_comb_ready_low: got %b expected 0", bInReady); end
    bOutReady = 1'b1;
    #1;
    nCmp++; if (bInReady !== 1'b1) begin nErr++; $display("FAIL b_comb_ready_high: got %b expected 1", bInReady); end
    nCmp++; if (bOutData !== 32'h77) begin nErr++; $display("FAIL b_data_77: got %h expected 00000077", bOutData); end
    step();
    modelQ.delete();
    for (int c = 0; c < 300; c++) begin
      bInValid = 1'($urandom_range(0, 1));
      bInData = $urandom;
      bOutReady = 1'($urandom_range(0, 1));
      #1;
      nCmp++; if (bOutValid !== (modelQ.size() != 0)) begin nErr++; $display("FAIL soakB_valid[%0d]: got %b expected %b", c, bOutValid, modelQ.size() != 0); end
      nCmp++; if (bInReady !== (modelQ.size() == 0 || bOutReady)) begin nErr++; $display("FAIL soakB_ready[%0d]: got %b expected %b", c, bInReady, (modelQ.size() == 0 || bOutReady)); end
      if (modelQ.size() != 0) begin
        nCmp++; if (bOutData !== modelQ[0]) begin nErr++; $display("FAIL soakB_data[%0d]: got %h expected %h", c, bOutData, modelQ[0]); end
      end
      if (bOutValid && bOutReady && modelQ.size() != 0) void'(modelQ.pop_front());
      if (bInValid && bInReady) modelQ.push_back(bInData);
      step();
    end
  endtask

  initial begin
    aFlush = 1'b0; aClr = 1'b0; aInValid = 1'b0; aInData = '0; aOutReady = 1'b0;
    bFlush = 1'b0; bClr = 1'b0; bInValid = 1'b0; bInData = '0; bOutReady = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_stall_count();
    test_soak_skid();
    test_skid0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
